// File: rtl/cpu_controller.sv
// Instruction decoder and multi-cycle control FSM for the 16-bit datapath.
// Latches one instruction per valid/ready handshake and sequences the MOV/ALU flow.
module cpu_controller #(
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  vsel,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WIMM   = 3'd2,
    S_GETA   = 3'd3,
    S_GETB   = 3'd4,
    S_EXEC   = 3'd5,
    S_WREG   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] ir_r;
  logic        accept_s;

  logic [2:0]  opcode_s;
  logic [1:0]  op_s;
  logic [2:0]  rn_s;
  logic [2:0]  rd_s;
  logic [1:0]  sh_s;
  logic [2:0]  rm_s;
  logic        is_movi_s;
  logic        is_mov_s;
  logic        is_alu_s;
  logic        is_mvn_s;
  logic        is_cmp_s;

  assign opcode_s  = ir_r[15:13];
  assign op_s      = ir_r[12:11];
  assign rn_s      = ir_r[10:8];
  assign rd_s      = ir_r[7:5];
  assign sh_s      = ir_r[4:3];
  assign rm_s      = ir_r[2:0];

  assign is_movi_s = (opcode_s == 3'b110) && (op_s == 2'b10);
  assign is_mov_s  = (opcode_s == 3'b110) && (op_s == 2'b00);
  assign is_alu_s  = (opcode_s == 3'b101);
  assign is_mvn_s  = is_alu_s && (op_s == 2'b11);
  assign is_cmp_s  = is_alu_s && (op_s == 2'b01);

  assign accept_s  = (state_r == S_WAIT) && instr_valid;
  assign sximm8    = {{8{ir_r[7]}}, ir_r[7:0]};
  assign sximm5    = {{11{ir_r[4]}}, ir_r[4:0]};
  assign bsel      = 1'b0;

  // State and instruction register; IR only changes on an accepted handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_WAIT;
      ir_r    <= 16'h0000;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        ir_r <= instr;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_WAIT: begin
        if (instr_valid) state_next_s = S_DECODE;
        else             state_next_s = S_WAIT;
      end
      S_DECODE: begin
        if (is_movi_s)                  state_next_s = S_WIMM;
        else if (is_mov_s || is_mvn_s)  state_next_s = S_GETB;
        else if (is_alu_s)              state_next_s = S_GETA;
        else                            state_next_s = S_ERROR;
      end
      S_GETA:  state_next_s = S_GETB;
      S_GETB:  state_next_s = S_EXEC;
      S_EXEC: begin
        if (is_cmp_s) state_next_s = S_WAIT;
        else          state_next_s = S_WREG;
      end
      S_WIMM:  state_next_s = S_WAIT;
      S_WREG:  state_next_s = S_WAIT;
      S_ERROR: begin
        if (ERR_STICKY) state_next_s = S_ERROR;
        else            state_next_s = S_WAIT;
      end
      default: state_next_s = S_WAIT;
    endcase
  end

  // Moore control outputs decoded from state and IR; everything idles low.
  always_comb begin
    instr_ready = 1'b0;
    readnum     = 3'd0;
    writenum    = 3'd0;
    write       = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    vsel        = 2'b00;
    asel        = 1'b0;
    shift       = 2'b00;
    ALUop       = 2'b00;
    done        = 1'b0;
    err         = 1'b0;
    case (state_r)
      S_WAIT:   instr_ready = 1'b1;
      S_DECODE: instr_ready = 1'b0;
      S_WIMM: begin
        write    = 1'b1;
        writenum = rn_s;
        vsel     = 2'b10;
        done     = 1'b1;
      end
      S_GETA: begin
        readnum = rn_s;
        loada   = 1'b1;
      end
      S_GETB: begin
        readnum = rm_s;
        loadb   = 1'b1;
        shift   = sh_s;
      end
      S_EXEC: begin
        shift = sh_s;
        // MOV and MVN pass B through with A forced to zero
        asel  = is_mov_s || is_mvn_s;
        if (is_mov_s) ALUop = 2'b00;
        else          ALUop = op_s;
        loadc = !is_cmp_s;
        loads = is_cmp_s;
        done  = is_cmp_s;
      end
      S_WREG: begin
        write    = 1'b1;
        writenum = rd_s;
        vsel     = 2'b00;
        done     = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: instr_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against a per-instruction
// cycle-schedule model; a second instance covers the non-sticky error mode.
module tb_cpu_controller;

  typedef struct packed {
    logic       rdy;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr;
    logic       la;
    logic       lb;
    logic       lc;
    logic       ls;
    logic [1:0] vsel;
    logic       asel;
    logic       bsel;
    logic [1:0] sh;
    logic [1:0] alu;
    logic       done;
    logic       err;
  } ctl_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  bit          use_ns;

  logic        st_ready, st_write, st_la, st_lb, st_lc, st_ls, st_asel, st_bsel, st_done, st_err;
  logic [2:0]  st_rn, st_wn;
  logic [1:0]  st_vsel, st_sh, st_alu;
  logic [15:0] st_s8, st_s5;

  logic        ns_ready, ns_write, ns_la, ns_lb, ns_lc, ns_ls, ns_asel, ns_bsel, ns_done, ns_err;
  logic [2:0]  ns_rn, ns_wn;
  logic [1:0]  ns_vsel, ns_sh, ns_alu;
  logic [15:0] ns_s8, ns_s5;

  ctl_t        obs_st, obs_ns, cur_c;
  logic [15:0] cur_s8, cur_s5;

  int          n_tests;
  int          n_fail;
  logic [15:0] cur_ir;
  ctl_t        exp_q[$];

  cpu_controller #(.ERR_STICKY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(st_ready), .readnum(st_rn), .writenum(st_wn), .write(st_write),
    .loada(st_la), .loadb(st_lb), .loadc(st_lc), .loads(st_ls), .vsel(st_vsel),
    .asel(st_asel), .bsel(st_bsel), .shift(st_sh), .ALUop(st_alu),
    .sximm8(st_s8), .sximm5(st_s5), .done(st_done), .err(st_err)
  );

  cpu_controller #(.ERR_STICKY(1'b0)) dut_ns (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(ns_ready), .readnum(ns_rn), .writenum(ns_wn), .write(ns_write),
    .loada(ns_la), .loadb(ns_lb), .loadc(ns_lc), .loads(ns_ls), .vsel(ns_vsel),
    .asel(ns_asel), .bsel(ns_bsel), .shift(ns_sh), .ALUop(ns_alu),
    .sximm8(ns_s8), .sximm5(ns_s5), .done(ns_done), .err(ns_err)
  );

  assign obs_st = {st_ready, st_rn, st_wn, st_write, st_la, st_lb, st_lc, st_ls,
                   st_vsel, st_asel, st_bsel, st_sh, st_alu, st_done, st_err};
  assign obs_ns = {ns_ready, ns_rn, ns_wn, ns_write, ns_la, ns_lb, ns_lc, ns_ls,
                   ns_vsel, ns_asel, ns_bsel, ns_sh, ns_alu, ns_done, ns_err};
  assign cur_c  = use_ns ? obs_ns : obs_st;
  assign cur_s8 = use_ns ? ns_s8 : st_s8;
  assign cur_s5 = use_ns ? ns_s5 : st_s5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ctl_t idle_ctl();
    ctl_t c;
    c = '0;
    c.rdy = 1'b1;
    return c;
  endfunction

  function automatic ctl_t err_ctl();
    ctl_t c;
    c = '0;
    c.err = 1'b1;
    return c;
  endfunction

  // Expected control word for every cycle after the accept edge.
  function automatic void build_seq(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    ctl_t c, ga, gb, ex, wb;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
    exp_q.delete();
    exp_q.push_back(ctl_t'(0));
    ga = '0; ga.rn = rn; ga.la = 1'b1;
    gb = '0; gb.rn = rm; gb.lb = 1'b1; gb.sh = sh;
    ex = '0; ex.sh = sh; ex.lc = 1'b1;
    wb = '0; wb.wr = 1'b1; wb.wn = rd; wb.done = 1'b1;
    if (opc == 3'b110 && op == 2'b10) begin
      c = '0; c.wr = 1'b1; c.wn = rn; c.vsel = 2'b10; c.done = 1'b1;
      exp_q.push_back(c);
    end else if (opc == 3'b110 && op == 2'b00) begin
      ex.asel = 1'b1; ex.alu = 2'b00;
      exp_q.push_back(gb); exp_q.push_back(ex); exp_q.push_back(wb);
    end else if (opc == 3'b101 && op == 2'b11) begin
      ex.asel = 1'b1; ex.alu = 2'b11;
      exp_q.push_back(gb); exp_q.push_back(ex); exp_q.push_back(wb);
    end else if (opc == 3'b101 && op == 2'b01) begin
      ex.lc = 1'b0; ex.ls = 1'b1; ex.alu = 2'b01; ex.done = 1'b1;
      exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(ex);
    end else if (opc == 3'b101) begin
      ex.alu = op;
      exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(ex); exp_q.push_back(wb);
    end else begin
      exp_q.push_back(err_ctl());
    end
  endfunction

  task automatic check_imm(input string tag);
    check_eq({tag, "_sximm8"}, {16'h0000, cur_s8}, {16'h0000, 16'($signed(cur_ir[7:0]))});
    check_eq({tag, "_sximm5"}, {16'h0000, cur_s5}, {16'h0000, 16'($signed(cur_ir[4:0]))});
  endtask

  task automatic run_instr(input logic [15:0] ir, input bit keep_valid);
    int n;
    n = 0;
    while (cur_c.rdy !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check_eq("wait_ready", {31'd0, cur_c.rdy}, 32'd1);
    check_eq("wait_ctl", {10'd0, cur_c}, {10'd0, idle_ctl()});
    check_imm("wait");
    instr       = ir;
    instr_valid = 1'b1;
    step();
    cur_ir      = ir;
    instr       = 16'($urandom);
    instr_valid = keep_valid;
    build_seq(ir);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) step();
      check_eq($sformatf("seq_%h_c%0d", ir, k + 1), {10'd0, cur_c}, {10'd0, exp_q[k]});
      check_imm("seq");
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0:       r[15:11] = 5'b110_10;
      1:       r[15:11] = 5'b110_00;
      2:       r[15:11] = 5'b101_00;
      3:       r[15:11] = 5'b101_01;
      4:       r[15:11] = 5'b101_10;
      default: r[15:11] = 5'b101_11;
    endcase
    return r;
  endfunction

  initial begin
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; instr = 16'h0000; instr_valid = 1'b0; use_ns = 1'b0; cur_ir = 16'h0000;
    #1;
    check_eq("reset_ctl", {10'd0, obs_st}, {10'd0, idle_ctl()});
    check_eq("reset_ctl_ns", {10'd0, obs_ns}, {10'd0, idle_ctl()});
    check_imm("reset");
    #10;
    reset_n = 1'b1;
    step();

    run_instr(16'hD1FE, 1'b1);
    run_instr(16'hA148, 1'b0);
    run_instr(16'hA800, 1'b0);
    run_instr(16'hD007, 1'b1);
    run_instr(16'hD1FE, 1'b1);
    for (int i = 0; i < 60; i++) begin
      run_instr(rand_instr(), 1'($urandom_range(0, 1)));
    end

    // reset while ADD sits in GETB
    step();
    instr = 16'hA148; instr_valid = 1'b1;
    step();
    cur_ir = 16'hA148; instr_valid = 1'b0;
    step(); step();
    check_eq("mid_add_loadb", {31'd0, obs_st.lb}, 32'd1);
    reset_n = 1'b0;
    #1;
    cur_ir = 16'h0000;
    check_eq("rst_async_ctl", {10'd0, obs_st}, {10'd0, idle_ctl()});
    check_imm("rst_async");
    #2;
    reset_n = 1'b1;
    step();
    check_eq("rst_release_ctl", {10'd0, obs_st}, {10'd0, idle_ctl()});

    // illegal opcode: non-sticky instance followed, sticky instance observed for 20 cycles
    use_ns = 1'b1;
    run_instr(16'hE000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("sticky_err", {10'd0, obs_st}, {10'd0, err_ctl()});
      check_eq("ns_back_wait", {10'd0, obs_ns}, {10'd0, idle_ctl()});
    end
    run_instr(16'hD1FE, 1'b0);
    step();
    check_eq("sticky_err_ignores", {10'd0, obs_st}, {10'd0, err_ctl()});

    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    use_ns = 1'b0;
    cur_ir = 16'h0000;
    step();
    check_eq("sticky_cleared", {10'd0, obs_st}, {10'd0, idle_ctl()});
    run_instr(16'hA148, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
